// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor. The operands are split into STAGES
// equal segments. Each stage adds one segment and passes its carry forward through a register.
module addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic                         en;
  logic [STAGES-1:0]            valid_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_q;
  logic [STAGES-1:0][WIDTH-1:0] sum_q;
  logic [STAGES-1:0]            carry_q;
  logic                         ovf_q;
  logic                         zero_q;

  logic [STAGES-1:0][WIDTH-1:0] a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_d;
  logic [STAGES-1:0][WIDTH-1:0] sum_d;
  logic [STAGES-1:0]            carry_in;
  logic [STAGES-1:0]            carry_d;
  logic [STAGES-1:0][SEG:0]     seg_res;
  logic                         msb_cin;
  logic                         ovf_d;
  logic                         zero_d;
  logic                         unused_tail;

  // A stall anywhere freezes the whole pipe, bubbles included.
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = valid_q[LAST];
  assign out_sum   = sum_q[LAST];
  assign out_carry = carry_q[LAST];
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

  // The last stage's operand copies are never read again.
  assign unused_tail = ^{a_q[LAST], b_q[LAST]};

  // Per-stage segment add; B is inverted once at entry and the carry-in enters at stage 0.
  always_comb begin
    a_d      = '0;
    b_d      = '0;
    sum_d    = '0;
    carry_in = '0;
    carry_d  = '0;
    seg_res  = '0;
    a_d[0]      = in_a;
    b_d[0]      = in_b ^ {WIDTH{in_sub}};
    carry_in[0] = in_sub;
    for (int k = 1; k < STAGES; k++) begin
      a_d[k]      = a_q[k-1];
      b_d[k]      = b_q[k-1];
      sum_d[k]    = sum_q[k-1];
      carry_in[k] = carry_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      seg_res[k] = {1'b0, a_d[k][k*SEG +: SEG]} + {1'b0, b_d[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, carry_in[k]};
      sum_d[k][k*SEG +: SEG] = seg_res[k][SEG-1:0];
      carry_d[k] = seg_res[k][SEG];
    end
    // Carry into the MSB is recovered from the MSB's own sum bit.
    msb_cin = a_d[LAST][WIDTH-1] ^ b_d[LAST][WIDTH-1] ^ sum_d[LAST][WIDTH-1];
    ovf_d   = msb_cin ^ carry_d[LAST];
    zero_d  = (sum_d[LAST] == '0);
  end

  // Pipeline registers; the flags register alongside the final sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (en) begin
      valid_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end
endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed corner cases on STAGES=4/1/16, random streams
// against an arithmetic reference model, and reset with operations in flight.
module tb_addsub_pipe;
  localparam int W = 16;
  localparam int LAT[3] = '{4, 1, 16};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid;
  logic         in_sub;
  logic         out_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         ir[3];
  logic         ov[3];
  logic         oc[3];
  logic         oo[3];
  logic         oz[3];
  logic [W-1:0] os[3];

  int  n_cmp = 0;
  int  n_err = 0;
  int  n_rx  = 0;
  logic mon_en    = 1'b0;
  logic rnd_ready = 1'b0;
  logic [18:0] exp_q[$];

  addsub_pipe #(.WIDTH(W), .STAGES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .out_valid(ov[0]), .out_ready(out_ready), .out_sum(os[0]),
    .out_carry(oc[0]), .out_ovf(oo[0]), .out_zero(oz[0]));
  addsub_pipe #(.WIDTH(W), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .out_valid(ov[1]), .out_ready(out_ready), .out_sum(os[1]),
    .out_carry(oc[1]), .out_ovf(oo[1]), .out_zero(oz[1]));
  addsub_pipe #(.WIDTH(W), .STAGES(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .out_valid(ov[2]), .out_ready(out_ready), .out_sum(os[2]),
    .out_carry(oc[2]), .out_ovf(oo[2]), .out_zero(oz[2]));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, returns {carry, ovf, zero, sum}
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    int ua, ub, sa, sb, ur, sr;
    logic [15:0] sum;
    logic c, o, z;
    ua  = int'({16'd0, a});
    ub  = int'({16'd0, b});
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    ur  = s ? ua - ub : ua + ub;
    sr  = s ? sa - sb : sa + sb;
    sum = ur[15:0];
    c   = s ? (ua >= ub) : (ur >= 65536);
    o   = (sr > 32767) || (sr < -32768);
    z   = (sum == 16'd0);
    return {c, o, z, sum};
  endfunction

  // Consumer readiness: always 1, or random when rnd_ready is set
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard and stall checks on u_dut4, sampled on the falling edge
  logic         stall_q = 1'b0;
  logic [W-1:0] hold_sum;
  logic [2:0]   hold_f;
  logic [18:0]  e;
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("in_ready", 32'(ir[0]), 32'(!ov[0] || out_ready));
      if (stall_q) begin
        check_eq("stall_valid", 32'(ov[0]), 32'd1);
        check_eq("stall_sum", 32'(os[0]), 32'(hold_sum));
        check_eq("stall_flags", 32'({oc[0], oo[0], oz[0]}), 32'(hold_f));
      end
      if (ov[0] && out_ready) begin
        check_eq("out_has_expect", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("rnd_sum", 32'(os[0]), 32'(e[15:0]));
          check_eq("rnd_carry", 32'(oc[0]), 32'(e[18]));
          check_eq("rnd_ovf", 32'(oo[0]), 32'(e[17]));
          check_eq("rnd_zero", 32'(oz[0]), 32'(e[16]));
        end
        n_rx <= n_rx + 1;
      end
      if (in_valid && ir[0]) exp_q.push_back(model(in_a, in_b, in_sub));
      stall_q  <= ov[0] && !out_ready;
      hold_sum <= os[0];
      hold_f   <= {oc[0], oo[0], oz[0]};
    end else begin
      stall_q <= 1'b0;
    end
  end

  // Present one op; returns at posedge+1 right after the accepting edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int waited = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_sub = s;
    @(negedge clk);
    while (!ir[0] && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 1000) check_eq("accept_timeout", 32'(ir[0]), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] es, input logic ec,
                          input logic eo, input logic ez);
    logic seen[3] = '{1'b0, 1'b0, 1'b0};
    send(a, b, s);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && !seen[d]) begin
          seen[d] = 1'b1;
          check_eq($sformatf("%s_lat_s%0d", tag, LAT[d]), 32'(cyc), 32'(LAT[d]));
          check_eq($sformatf("%s_sum_s%0d", tag, LAT[d]), 32'(os[d]), 32'(es));
          check_eq($sformatf("%s_carry_s%0d", tag, LAT[d]), 32'(oc[d]), 32'(ec));
          check_eq($sformatf("%s_ovf_s%0d", tag, LAT[d]), 32'(oo[d]), 32'(eo));
          check_eq($sformatf("%s_zero_s%0d", tag, LAT[d]), 32'(oz[d]), 32'(ez));
        end
      end
      @(posedge clk);
      #1;
    end
    for (int d = 0; d < 3; d++)
      check_eq($sformatf("%s_seen_s%0d", tag, LAT[d]), 32'(seen[d]), 32'd1);
  endtask

  task automatic rand_stream(input string tag, input logic toggle);
    int base;
    int waited = 0;
    logic [W-1:0] a, b;
    base = n_rx;
    rnd_ready = toggle;
    mon_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a = 16'($urandom);
      b = (i % 10 == 0) ? a : 16'($urandom);
      if (i % 13 == 0) a = 16'h7FFF;
      if (i % 17 == 0) b = 16'h8000;
      send(a, b, 1'($urandom_range(0, 1)));
    end
    while (exp_q.size() != 0 && waited < 2000) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
    check_eq($sformatf("%s_count", tag), 32'(n_rx - base), 32'd100);
    check_eq($sformatf("%s_left", tag), 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    rnd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached limit 500000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("rst_valid_%0d", d), 32'(ov[d]), 32'd0);
      check_eq($sformatf("rst_sum_%0d", d), 32'(os[d]), 32'd0);
      check_eq($sformatf("rst_flags_%0d", d), 32'({oc[d], oo[d], oz[d]}), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("in_ready_after_rst", 32'(ir[0]), 32'd1);
    @(posedge clk);
    #1;

    directed("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    directed("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    directed("sub_ovf",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    directed("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    directed("sub_equal",  16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

    rand_stream("stream_ready", 1'b0);
    rand_stream("stream_stall", 1'b1);

    // Three ops in flight, then a one-cycle reset that also carries a valid op
    send(16'h1111, 16'h2222, 1'b0);
    send(16'h3333, 16'h0001, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1;
    in_a = 16'h0001;
    in_b = 16'h0001;
    in_sub = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++)
      check_eq($sformatf("midrst_sum_%0d", d), 32'(os[d]), 32'd0);
    for (int cyc = 0; cyc < 20; cyc++) begin
      for (int d = 0; d < 3; d++)
        check_eq($sformatf("midrst_valid_%0d", d), 32'(ov[d]), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    directed("post_rst", 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
